line_fill_memory: RTL and testbench

LINE_FILL_MEMORY -- requirements
Module: line_fill_memory

---
 rtl/line_fill_memory.sv | 141 ++++++++++++++
 tb/tb_line_fill_memory.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_memory.sv
// Word-addressed backing store that answers cache line fills as a burst of
// 16-bit beats after a fixed latency, and absorbs single-word writes.
module line_fill_memory #(
    parameter int LATENCY     = 4,
    parameter int LINE_WORDS  = 8,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [15:0] rsp_addr,
    output logic        fill_done,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RWAIT = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
    localparam logic [1:0] WWAIT = 2'd3;

    localparam logic [3:0]    RD_WAIT   = 4'(LATENCY - 1);
    localparam logic [3:0]    WR_WAIT   = 4'(LATENCY - 2);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [15:0]   base_q, base_d;

    logic [15:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          wr_en;
    logic          last_beat;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    // Gating with rst keeps the requester stalled while reset is held.
    assign req_ready = rst & (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = req_valid & req_ready;
    assign wr_en     = accept & req_write;
    assign last_beat = (beat_q == LAST_BEAT);

    // Truncation to AW bits is the modulo-DEPTH wrap for both paths.
    assign wr_idx = AW'(req_addr >> 1);
    assign rd_idx = AW'(base_q >> 1) + AW'(beat_q);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_write) begin
                        state_d = WWAIT;
                        wait_d  = WR_WAIT;
                    end else begin
                        state_d = RWAIT;
                        wait_d  = RD_WAIT;
                        base_d  = {req_addr[15:4], 4'h0};
                    end
                end
            end
            RWAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = BURST;
                    beat_d  = '0;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            BURST: begin
                if (last_beat) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            WWAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rsp_valid = (state_q == BURST);
        rsp_data  = '0;
        rsp_addr  = '0;
        fill_done = 1'b0;
        if (rsp_valid) begin
            rsp_data  = mem[rd_idx];
            rsp_addr  = base_q + (16'(beat_q) << 1);
            fill_done = last_beat;
        end
        if (state_q == WWAIT) begin
            fill_done = (wait_q == 4'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
        end
    end

    // The array has no reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_line_fill_memory.sv
// Self-checking bench for line_fill_memory: directed vector table, corner
// sequences and random traffic against a byte-address memory model.
module tb_line_fill_memory;

    localparam int LAT   = 4;
    localparam int LW    = 8;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [15:0] rsp_addr;
    logic        fill_done;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] ref_mem [DEPTH];
    logic [15:0] cap_addr [LW];
    logic [15:0] cap_data [LW];

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          beat;
        logic [15:0] e_addr;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs [13];

    line_fill_memory #(
        .LATENCY(LAT),
        .LINE_WORDS(LW),
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_addr(rsp_addr),
        .fill_done(fill_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_addr(input logic [15:0] a,
                                             input int k);
        return (a & 16'hFFF0) + 16'(2 * k);
    endfunction

    // Byte address -> word index, wrapping modulo DEPTH (1024 words).
    function automatic logic [9:0] word_of(input logic [15:0] a);
        return 10'(a >> 1);
    endfunction

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        chk("wr_ready", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
        req_write = 1'b0;
        ref_mem[word_of(a)] = d;
        for (int i = 0; i < LAT - 1; i++) begin
            chk("wr_busy", 32'({busy, req_ready, rsp_valid}), 32'(3'b100));
            chk("wr_done", 32'(fill_done), 32'(i == LAT - 2));
            step();
        end
        chk("wr_idle", 32'({busy, req_ready, fill_done}), 32'(3'b010));
    endtask

    task automatic mid_reset();
        int bad;
        bad = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_async", 32'({rsp_valid, fill_done, busy, req_ready}), 32'(0));
        chk("rst_bus", {rsp_data, rsp_addr}, 32'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'(1));
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid || fill_done || busy) bad++;
            step();
        end
        chk("rst_quiet", 32'(bad), 32'(0));
    endtask

    task automatic do_read(input logic [15:0] a, input int inj_beat,
                           input int rst_beat);
        logic [15:0] ea;
        chk("rd_ready", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        req_wdata = 16'h0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            chk("rd_wait", 32'({busy, req_ready, rsp_valid, fill_done}),
                32'(4'b1000));
            chk("rd_wait_bus", {rsp_data, rsp_addr}, 32'(0));
            step();
        end
        for (int k = 0; k < LW; k++) begin
            ea = exp_addr(a, k);
            cap_addr[k] = rsp_addr;
            cap_data[k] = rsp_data;
            chk("beat_valid", 32'({rsp_valid, busy, req_ready}), 32'(3'b110));
            chk("beat_addr", 32'(rsp_addr), 32'(ea));
            chk("beat_data", 32'(rsp_data), 32'(ref_mem[word_of(ea)]));
            chk("beat_done", 32'(fill_done), 32'(k == LW - 1));
            if (k == rst_beat) begin
                mid_reset();
                return;
            end
            if (k == inj_beat) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = ea;
                req_wdata = ~ref_mem[word_of(ea)];
            end
            step();
            req_valid = 1'b0;
            req_write = 1'b0;
        end
        chk("rd_idle", 32'({busy, req_ready, rsp_valid, fill_done}),
            32'(4'b0100));
    endtask

    initial begin
        int beats;
        int fds;
        int idles;
        int cyc;

        vecs[0]  = '{1'b1, 16'h0006, 16'hBEEF, 0, 16'h0, 16'h0};
        vecs[1]  = '{1'b0, 16'h000A, 16'h0, 0, 16'h0000, 16'hC000};
        vecs[2]  = '{1'b0, 16'h000A, 16'h0, 3, 16'h0006, 16'hBEEF};
        vecs[3]  = '{1'b0, 16'h000A, 16'h0, 7, 16'h000E, 16'hC007};
        vecs[4]  = '{1'b1, 16'h0013, 16'h1234, 0, 16'h0, 16'h0};
        vecs[5]  = '{1'b0, 16'h0810, 16'h0, 1, 16'h0812, 16'h1234};
        vecs[6]  = '{1'b0, 16'h0810, 16'h0, 0, 16'h0810, 16'hC008};
        vecs[7]  = '{1'b0, 16'h0810, 16'h0, 7, 16'h081E, 16'hC00F};
        vecs[8]  = '{1'b1, 16'hFFFF, 16'h8888, 0, 16'h0, 16'h0};
        vecs[9]  = '{1'b0, 16'h07F5, 16'h0, 7, 16'h07FE, 16'h8888};
        vecs[10] = '{1'b0, 16'hF7F0, 16'h0, 0, 16'hF7F0, 16'hC3F8};
        vecs[11] = '{1'b1, 16'h0814, 16'hA5A5, 0, 16'h0, 16'h0};
        vecs[12] = '{1'b0, 16'h001F, 16'h0, 2, 16'h0014, 16'hA5A5};

        step();
        step();
        chk("reset_outs", 32'({req_ready, busy, rsp_valid, fill_done}), 32'(0));
        chk("reset_bus", {rsp_data, rsp_addr}, 32'(0));
        rst = 1'b1;
        #1;
        chk("reset_release", 32'({req_ready, busy}), 32'(2'b10));
        step();

        for (int i = 0; i < DEPTH; i++) begin
            do_write(16'(2 * i), 16'hC000 + 16'(i));
        end

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data);
            end else begin
                do_read(vecs[i].addr, -1, -1);
                chk("vec_addr", 32'(cap_addr[vecs[i].beat]), 32'(vecs[i].e_addr));
                chk("vec_data", 32'(cap_data[vecs[i].beat]), 32'(vecs[i].e_data));
            end
        end

        // Back-to-back reads with req_valid held high.
        beats = 0;
        fds = 0;
        idles = 0;
        cyc = 0;
        chk("b2b_ready", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0040;
        step();
        while (fds < 2 && cyc < 60) begin
            if (rsp_valid) beats++;
            if (!busy) idles++;
            if (busy && req_ready) idles += 100;
            if (fill_done) begin
                fds++;
                if (fds == 2) req_valid = 1'b0;
            end
            step();
            cyc++;
        end
        req_valid = 1'b0;
        chk("b2b_done", 32'(fds), 32'(2));
        chk("b2b_beats", 32'(beats), 32'(2 * LW));
        chk("b2b_idle", 32'(idles), 32'(1));
        chk("b2b_cycles", 32'(cyc), 32'(2 * (LAT + LW) + 1));
        chk("b2b_end", 32'({busy, req_ready}), 32'(2'b01));

        // Write pulsed during a burst is ignored.
        do_read(16'h0100, 2, -1);
        do_read(16'h0100, -1, -1);
        chk("reject_data", 32'(cap_data[2]), 32'(16'hC082));

        // Reset at beat 3 aborts the fill; array contents survive.
        do_read(16'h0000, -1, 3);
        do_read(16'h0000, -1, -1);
        chk("persist_data", 32'(cap_data[3]), 32'(16'hBEEF));

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(16'($urandom), 16'($urandom));
            else
                do_read(16'($urandom), -1, -1);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
